// File: rtl/reload_timer.sv
// -----------------------------------------------------------------------------
// reload_timer
//   Up/down counter-timer with a reload register, one-shot or periodic
//   operation and a registered terminal-count pulse. It serves as the general
//   timebase and event counter for peripheral blocks.
//
//   Optional feature macro: RELOAD_TIMER_PRESCALE_EN
//     When defined, a PSC port and an internal prescale counter are added.
//     The count then steps once every PSC+1 enabled RUN cycles.
//     When undefined, the count steps on every enabled RUN cycle.
//
// Parameters
//   bitwidth    width of IN, OUT, count and reload
//   PRESCALE_W  width of PSC and the prescale counter
//
// Ports
//   CLK       clock, all state updates on posedge
//   RST_N     asynchronous active-low reset
//   LD        load: reload <= IN, count <= (DIR ? 0 : IN)
//   IN        load value
//   EN        step enable, qualifies stepping in RUN only
//   DIR       0 = count down to 0, 1 = count up to reload
//   PERIODIC  1 = auto-reload at terminal, 0 = one-shot (stop in DONE)
//   START     IDLE/DONE -> RUN (DONE also restarts the count)
//   STOP      RUN/DONE -> IDLE, count held
//   PSC       prescale divisor minus 1 (only with RELOAD_TIMER_PRESCALE_EN)
//   OUT       current count
//   TC        one-cycle registered pulse on each terminal event
//   BUSY      1 while in RUN
//
// Handshake: this block has no valid/ready interfaces. Every control input is
// a level sampled on each rising clock edge. Per edge, exactly one of
// LD > STOP > START > step takes effect.
// -----------------------------------------------------------------------------
module reload_timer #(
    parameter int bitwidth   = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  LD,
    input  logic [bitwidth-1:0]   IN,
    input  logic                  EN,
    input  logic                  DIR,
    input  logic                  PERIODIC,
    input  logic                  START,
    input  logic                  STOP,
`ifdef RELOAD_TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] PSC,
`endif
    output logic [bitwidth-1:0]   OUT,
    output logic                  TC,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_busy;
    logic [bitwidth-1:0]   r_count;
    logic [bitwidth-1:0]   r_reload;
    logic                  r_tc;
    logic [bitwidth-1:0]   w_count_nxt;
    logic [bitwidth-1:0]   w_reload_nxt;
    logic                  w_tc_nxt;
    logic                  w_tick;
    logic                  w_step;
    logic                  w_terminal;
    logic [bitwidth-1:0]   w_restart_val;

`ifdef RELOAD_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [PRESCALE_W-1:0] w_pcnt_nxt;

    assign w_tick = (r_pcnt == PSC);
`else
    // Without the prescaler every enabled cycle is a tick; any legal width is > 0.
    assign w_tick = (PRESCALE_W > 0);
`endif

    assign w_step        = (r_state == S_RUN) && EN && w_tick;
    assign w_terminal    = DIR ? (r_count == r_reload) : (r_count == '0);
    // Value the count restarts from after a periodic terminal or START in DONE.
    assign w_restart_val = DIR ? '0 : r_reload;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        if (LD) begin
            if (r_state == S_DONE) begin
                w_state_nxt = S_IDLE;
            end
        end else if (STOP) begin
            w_state_nxt = S_IDLE;
        end else if (START && (r_state != S_RUN)) begin
            w_state_nxt = S_RUN;
        end else if (w_step && w_terminal && !PERIODIC) begin
            w_state_nxt = S_DONE;
        end
    end

    // ------------------------------------------------------- output / datapath
    always_comb begin
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
`ifdef RELOAD_TIMER_PRESCALE_EN
        w_pcnt_nxt   = r_pcnt;
`endif
        if (LD) begin
            w_reload_nxt = IN;
            w_count_nxt  = DIR ? '0 : IN;
`ifdef RELOAD_TIMER_PRESCALE_EN
            w_pcnt_nxt   = '0;
`endif
        end else if (STOP) begin
`ifdef RELOAD_TIMER_PRESCALE_EN
            w_pcnt_nxt   = '0;
`endif
        end else if (START && (r_state != S_RUN)) begin
            if (r_state == S_DONE) begin
                w_count_nxt = w_restart_val;
            end
`ifdef RELOAD_TIMER_PRESCALE_EN
            w_pcnt_nxt   = '0;
`endif
        end else if ((r_state == S_RUN) && EN) begin
`ifdef RELOAD_TIMER_PRESCALE_EN
            w_pcnt_nxt = w_tick ? '0 : r_pcnt + 1'b1;
`endif
            if (w_step) begin
                if (w_terminal) begin
                    w_tc_nxt = 1'b1;
                    // One-shot holds the terminal value; periodic restarts.
                    if (PERIODIC) begin
                        w_count_nxt = w_restart_val;
                    end
                end else if (DIR) begin
                    // Wraps through all-ones if count was above reload.
                    w_count_nxt = r_count + 1'b1;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------ datapath reg
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
`ifdef RELOAD_TIMER_PRESCALE_EN
            r_pcnt   <= '0;
`endif
        end else begin
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
`ifdef RELOAD_TIMER_PRESCALE_EN
            r_pcnt   <= w_pcnt_nxt;
`endif
        end
    end

    assign OUT  = r_count;
    assign TC   = r_tc;
    assign BUSY = r_busy;

endmodule
